// File: rtl/hop_sched_pkg.sv
// Shared constants for the hop scheduler: settings register map, ctrl bit
// positions and FSM state encoding.
package hop_sched_pkg;

  localparam int unsigned SET_ADDR_WIDTH = 8;
  localparam int unsigned SET_DATA_WIDTH = 32;

  localparam logic [SET_ADDR_WIDTH-1:0] ADDR_STAGE0   = 8'd0;
  localparam logic [SET_ADDR_WIDTH-1:0] ADDR_STAGE1   = 8'd1;
  localparam logic [SET_ADDR_WIDTH-1:0] ADDR_STAGE2   = 8'd2;
  localparam logic [SET_ADDR_WIDTH-1:0] ADDR_STAGE3   = 8'd3;
  localparam logic [SET_ADDR_WIDTH-1:0] ADDR_TABLE    = 8'd4;
  localparam logic [SET_ADDR_WIDTH-1:0] ADDR_NUM_HOPS = 8'd5;
  localparam logic [SET_ADDR_WIDTH-1:0] ADDR_DWELL    = 8'd6;
  localparam logic [SET_ADDR_WIDTH-1:0] ADDR_CTRL     = 8'd7;

  localparam int unsigned CTRL_RUN     = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_CLR_ERR = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DWELL     = 2'd3
  } hop_state_e;

endpackage

// File: rtl/hop_sched_if.sv
// Word handoff between the hop scheduler (master) and the scan-chain
// serializer (slave).
interface hop_sched_if #(
  parameter int unsigned TX_BITS_WIDTH = 128
);
  logic [TX_BITS_WIDTH-1:0] hop_word;
  logic                     hop_valid;
  logic                     hop_ready;
  logic                     scan_done;

  modport master (output hop_word, output hop_valid, input hop_ready, input scan_done);
  modport slave  (input hop_word, input hop_valid, output hop_ready, output scan_done);
endinterface

// File: rtl/hop_sched_table.sv
// Hop word storage: one synchronous write port, one combinational read port.
// Contents are deliberately left unreset.
module hop_sched_table #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IDX_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [IDX_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/hop_sched.sv
// Hop scheduler: issues table words to the serializer, waits for its
// load-chip pulse, dwells, and steps circularly or single-shot.
module hop_sched
  import hop_sched_pkg::*;
#(
  parameter int unsigned TX_BITS_WIDTH = 128,
  parameter int unsigned NUM_HOPS      = 16,
  parameter int unsigned HOP_IDX_WIDTH = 4,
  parameter int unsigned DWELL_WIDTH   = 32,
  parameter int unsigned DONE_TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set_stb,
  input  logic [SET_ADDR_WIDTH-1:0] set_addr,
  input  logic [SET_DATA_WIDTH-1:0] set_data,
  hop_sched_if.master               hop,
  output logic [HOP_IDX_WIDTH-1:0]  hop_idx,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned NH_WIDTH    = HOP_IDX_WIDTH + 1;
  localparam int unsigned TIMER_WIDTH = $clog2(DONE_TIMEOUT);

  hop_state_e               state_q, state_d;
  logic [TX_BITS_WIDTH-1:0] stage_q, stage_d;
  logic [NH_WIDTH-1:0]      num_hops_q, num_hops_d;
  logic [DWELL_WIDTH-1:0]   dwell_q, dwell_d;
  logic                     run_q, run_d;
  logic                     oneshot_q, oneshot_d;
  logic                     err_q, err_d;
  logic [HOP_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [TX_BITS_WIDTH-1:0] word_q, word_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
  logic [DWELL_WIDTH-1:0]   dwell_cnt_q, dwell_cnt_d;

  logic                     tbl_we_c;
  logic                     run_rise_c;
  logic [HOP_IDX_WIDTH-1:0] tbl_raddr_c;
  logic [TX_BITS_WIDTH-1:0] tbl_rdata_c;
  logic [NH_WIDTH-1:0]      num_hops_eff_c;
  logic                     wrap_c;

  function automatic logic [NH_WIDTH-1:0] clamp_hops(input logic [NH_WIDTH-1:0] n);
    if (n == '0) return NH_WIDTH'(1);
    if (n > NH_WIDTH'(NUM_HOPS)) return NH_WIDTH'(NUM_HOPS);
    return n;
  endfunction

  // Reset leaves num_hops at 0, which still schedules one hop.
  assign num_hops_eff_c = (num_hops_q == '0) ? NH_WIDTH'(1) : num_hops_q;
  assign wrap_c         = ({1'b0, idx_q} >= (num_hops_eff_c - NH_WIDTH'(1)));

  // Address of the word the next ISSUE entry will latch.
  assign tbl_raddr_c = ((state_q == ST_IDLE) || wrap_c) ? '0
                                                        : idx_q + HOP_IDX_WIDTH'(1);

  hop_sched_table #(
    .WIDTH     (TX_BITS_WIDTH),
    .DEPTH     (NUM_HOPS),
    .IDX_WIDTH (HOP_IDX_WIDTH)
  ) u_table (
    .clk     (clk),
    .we      (tbl_we_c),
    .waddr   (set_data[HOP_IDX_WIDTH-1:0]),
    .wdata   (stage_q),
    .raddr   (tbl_raddr_c),
    .rdata_c (tbl_rdata_c)
  );

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    num_hops_d  = num_hops_q;
    dwell_d     = dwell_q;
    run_d       = run_q;
    oneshot_d   = oneshot_q;
    err_d       = err_q;
    idx_d       = idx_q;
    word_d      = word_q;
    valid_d     = valid_q;
    timer_d     = timer_q;
    dwell_cnt_d = dwell_cnt_q;
    tbl_we_c    = 1'b0;
    run_rise_c  = 1'b0;

    // Settings decode
    if (set_stb) begin
      case (set_addr)
        ADDR_STAGE0:   stage_d[31:0]   = set_data;
        ADDR_STAGE1:   stage_d[63:32]  = set_data;
        ADDR_STAGE2:   stage_d[95:64]  = set_data;
        ADDR_STAGE3:   stage_d[127:96] = set_data;
        ADDR_TABLE:    tbl_we_c        = 1'b1;
        ADDR_NUM_HOPS: num_hops_d      = clamp_hops(set_data[NH_WIDTH-1:0]);
        ADDR_DWELL:    dwell_d         = set_data[DWELL_WIDTH-1:0];
        ADDR_CTRL: begin
          run_rise_c = set_data[CTRL_RUN] & ~run_q;
          run_d      = set_data[CTRL_RUN];
          oneshot_d  = set_data[CTRL_ONESHOT];
          if (set_data[CTRL_CLR_ERR]) err_d = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (run_rise_c) begin
          state_d = ST_ISSUE;
          idx_d   = tbl_raddr_c;
          word_d  = tbl_rdata_c;
        end
      end
      ST_ISSUE: begin
        // A transfer already on the bus wins over a same-cycle run clear.
        if (valid_q && hop.hop_ready) begin
          state_d = ST_WAIT_DONE;
          valid_d = 1'b0;
          timer_d = '0;
        end else if (!run_d) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (hop.scan_done) begin
          if (run_d) begin
            state_d     = ST_DWELL;
            dwell_cnt_d = dwell_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (timer_q == TIMER_WIDTH'(DONE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          run_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
      ST_DWELL: begin
        if (!run_d) begin
          state_d = ST_IDLE;
        end else if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - DWELL_WIDTH'(1);
        end else begin
          idx_d = tbl_raddr_c;
          if (wrap_c && oneshot_q) begin
            run_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
            word_d  = tbl_rdata_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      num_hops_q  <= '0;
      dwell_q     <= '0;
      run_q       <= 1'b0;
      oneshot_q   <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      timer_q     <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      num_hops_q  <= num_hops_d;
      dwell_q     <= dwell_d;
      run_q       <= run_d;
      oneshot_q   <= oneshot_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      timer_q     <= timer_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign hop.hop_word  = word_q;
  assign hop.hop_valid = valid_q;
  assign hop_idx       = idx_q;
  assign busy          = busy_q;
  assign timeout_err   = err_q;

endmodule
